// File: rtl/pu_or1k_pfpu32_addsub_rnd.sv
// pfpu32 add/sub final normalize, round and pack stage (2-stage pipe).
// Define PU_OR1K_PFPU32_FTZ_EN to flush tiny results to signed zero.
module pu_or1k_pfpu32_addsub_rnd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        adv_i,
    input  logic [1:0]  rmode_i,
    input  logic        add_rdy_i,
    input  logic        add_sign_i,
    input  logic        add_sub_0_i,
    input  logic [4:0]  add_shl_i,
    input  logic [9:0]  add_exp10shl_i,
    input  logic [9:0]  add_exp10sh0_i,
    input  logic [27:0] add_fract28_i,
    input  logic        add_inv_i,
    input  logic        add_inf_i,
    input  logic        add_snan_i,
    input  logic        add_qnan_i,
    input  logic        add_anan_sign_i,
    output logic        rnd_rdy_o,
    output logic [31:0] rnd_result_o,
    output logic        rnd_inexact_o,
    output logic        rnd_overflow_o,
    output logic        rnd_underflow_o,
    output logic        rnd_invalid_o,
    output logic        rnd_inf_o,
    output logic        rnd_zero_o,
    output logic        rnd_snan_o
);

    typedef struct packed {
        logic        sign;
        logic        sub0;
        logic        inv;
        logic        inf;
        logic        snan;
        logic        qnan;
        logic        anan;
        logic [1:0]  rmode;
        logic [23:0] m;
        logic        r;
        logic        s;
        logic [9:0]  exp;
        logic        tiny;
    } stg_a_t;

    typedef struct packed {
        logic [31:0] res;
        logic        inexact;
        logic        overflow;
        logic        underflow;
        logic        invalid;
        logic        inf;
        logic        zero;
        logic        snan;
    } stg_b_t;

    stg_a_t      a_d, a_q;
    stg_b_t      b_d, b_q;
    logic        a_rdy_d, a_rdy_q;
    logic        b_rdy_d, b_rdy_q;

    logic [27:0] sh_a;
    logic [9:0]  exp_a;
    logic        stk_a;

    logic        inc_b;
    logic [24:0] sum_b;
    logic [9:0]  exp_b;
    logic [23:0] mant_b;
    logic        ovf_b;
    logic        to_inf_b;
    logic [31:0] rnd_b;
    logic        inx_b;
    logic        unf_b;

    // Ready bits: flush wins over advance, otherwise hold when stalled
    always_comb begin
        a_rdy_d = a_rdy_q;
        b_rdy_d = b_rdy_q;
        if (flush_i) begin
            a_rdy_d = 1'b0;
            b_rdy_d = 1'b0;
        end else if (adv_i) begin
            a_rdy_d = add_rdy_i;
            b_rdy_d = a_rdy_q;
        end
    end

    // Stage A: undo carry or apply left shift, extract m/r/s, detect tiny
    always_comb begin
        a_d   = a_q;
        sh_a  = add_fract28_i << add_shl_i;
        exp_a = add_exp10shl_i;
        stk_a = 1'b0;
        if (add_fract28_i[27]) begin
            sh_a  = {1'b0, add_fract28_i[27:1]};
            exp_a = add_exp10sh0_i + 10'd1;
            stk_a = add_fract28_i[0];
        end
        if (adv_i) begin
            a_d.sign  = add_sign_i;
            a_d.sub0  = add_sub_0_i;
            a_d.inv   = add_inv_i;
            a_d.inf   = add_inf_i;
            a_d.snan  = add_snan_i;
            a_d.qnan  = add_qnan_i;
            a_d.anan  = add_anan_sign_i;
            a_d.rmode = rmode_i;
            a_d.m     = sh_a[26:3];
            a_d.r     = sh_a[2];
            a_d.s     = (|sh_a[1:0]) | stk_a;
            a_d.tiny  = ~sh_a[26];
            a_d.exp   = sh_a[26] ? exp_a : 10'd0;
        end
    end

    // Stage B: round by mode, handle overflow, select result by priority
    always_comb begin
        b_d = b_q;
        unique case (a_q.rmode)
            2'd0: inc_b = a_q.r & (a_q.s | a_q.m[0]);
            2'd1: inc_b = 1'b0;
            2'd2: inc_b = ~a_q.sign & (a_q.r | a_q.s);
            2'd3: inc_b = a_q.sign & (a_q.r | a_q.s);
        endcase
        sum_b  = {1'b0, a_q.m} + {24'd0, inc_b};
        exp_b  = a_q.exp;
        mant_b = sum_b[23:0];
        if (sum_b[24]) begin
            exp_b  = a_q.exp + 10'd1;
            mant_b = 24'h800000;
        end else if (a_q.tiny && sum_b[23]) begin
            exp_b  = 10'd1;
        end
        ovf_b    = (exp_b >= 10'd255);
        to_inf_b = (a_q.rmode == 2'd0) ||
                   (a_q.rmode == 2'd2 && !a_q.sign) ||
                   (a_q.rmode == 2'd3 && a_q.sign);
        inx_b    = a_q.r | a_q.s | ovf_b;
        unf_b    = a_q.tiny & inx_b;
        if (ovf_b) begin
            rnd_b = to_inf_b ? {a_q.sign, 8'hFF, 23'd0}
                             : {a_q.sign, 31'h7F7FFFFF};
        end else begin
            rnd_b = {a_q.sign, exp_b[7:0], mant_b[22:0]};
        end
`ifdef PU_OR1K_PFPU32_FTZ_EN
        if (!ovf_b && rnd_b[30:23] == 8'd0 && rnd_b[22:0] != 23'd0) begin
            rnd_b = {a_q.sign, 31'd0};
            inx_b = 1'b1;
            unf_b = 1'b1;
        end
`endif
        if (adv_i) begin
            b_d = '0;
            if (a_q.snan || a_q.qnan || a_q.inv) begin
                b_d.res     = {(a_q.snan | a_q.qnan) & a_q.anan,
                               31'h7FC00000};
                b_d.invalid = a_q.inv | a_q.snan;
                b_d.snan    = a_q.snan;
            end else if (a_q.inf) begin
                b_d.res = {a_q.sign, 8'hFF, 23'd0};
                b_d.inf = 1'b1;
            end else if (a_q.sub0) begin
                b_d.res  = {a_q.rmode == 2'd3, 31'd0};
                b_d.zero = 1'b1;
            end else begin
                b_d.res       = rnd_b;
                b_d.inexact   = inx_b;
                b_d.overflow  = ovf_b;
                b_d.underflow = unf_b;
                b_d.zero      = (rnd_b[30:0] == 31'd0);
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdy_q <= 1'b0;
            b_rdy_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            a_rdy_q <= a_rdy_d;
            b_rdy_q <= b_rdy_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign rnd_rdy_o       = b_rdy_q;
    assign rnd_result_o    = b_q.res;
    assign rnd_inexact_o   = b_q.inexact;
    assign rnd_overflow_o  = b_q.overflow;
    assign rnd_underflow_o = b_q.underflow;
    assign rnd_invalid_o   = b_q.invalid;
    assign rnd_inf_o       = b_q.inf;
    assign rnd_zero_o      = b_q.zero;
    assign rnd_snan_o      = b_q.snan;

endmodule
